// File: rtl/heap_array_pkg.sv
// Shared sizing constants, types, FSM states and the heap index helper for heap_array_pop.
package heap_array_pkg;

    localparam int MemoryElementWidth = 12;
    localparam int NArea              = 10;
    localparam int NArrays            = 2000;
    localparam int NHeap              = 10000;

    localparam int SizeAddrW = $clog2(NArrays);
    localparam int HeapAddrW = $clog2(NHeap);
    localparam int HeapIdxW  = HeapAddrW + 1;

    typedef logic [MemoryElementWidth-1:0] elem_t;
    typedef logic [HeapIdxW-1:0]           heap_idx_t;

    localparam elem_t     NAreaE   = elem_t'(NArea);
    localparam elem_t     NArraysE = elem_t'(NArrays);
    localparam heap_idx_t NHeapI   = heap_idx_t'(NHeap);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SIZE   = 3'd1,
        CHECK     = 3'd2,
        RD_HEAP   = 3'd3,
        WAIT_HEAP = 3'd4,
        CLEAR     = 3'd5,
        RESP      = 3'd6
    } state_e;

    // One bit wider than the heap address so out-of-range slots stay detectable.
    function automatic heap_idx_t heap_index(input elem_t array, input elem_t index);
        return heap_idx_t'(array) * heap_idx_t'(NArea) + heap_idx_t'(index);
    endfunction

endpackage

// File: rtl/heap_array_pop.sv
// Pops the last element of a heap-resident array through external size/heap RAMs.
// Define HEAP_ARRAY_POP_CLEAR_EN to zero the popped heap slot after reading it.
module heap_array_pop
    import heap_array_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [11:0]          req_array,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [11:0]          rsp_data,
    output logic                 rsp_underflow,
    output logic [SizeAddrW-1:0] size_addr,
    input  logic [11:0]          size_rdata,
    output logic                 size_we,
    output logic [11:0]          size_wdata,
    output logic [HeapAddrW-1:0] heap_addr,
    input  logic [11:0]          heap_rdata,
    output logic                 heap_we,
    output logic [11:0]          heap_wdata
);

    state_e                state_q, state_d;
    elem_t                 array_q, array_d;
    logic                  bad_q, bad_d;
    logic [SizeAddrW-1:0]  size_addr_q, size_addr_d;
    logic                  size_we_q, size_we_d;
    elem_t                 size_wdata_q, size_wdata_d;
    logic [HeapAddrW-1:0]  heap_addr_q, heap_addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    elem_t                 rsp_data_q, rsp_data_d;
    logic                  rsp_underflow_q, rsp_underflow_d;

    elem_t     new_size;
    heap_idx_t slot_idx;
    logic      pop_fail;

    // Every corrupt or out-of-range case collapses into an underflow response.
    assign new_size = size_rdata - elem_t'(1);
    assign slot_idx = heap_index(array_q, new_size);
    assign pop_fail = bad_q || (size_rdata == '0) || (size_rdata > NAreaE) || (slot_idx >= NHeapI);

`ifdef HEAP_ARRAY_POP_CLEAR_EN
    logic heap_we_q, heap_we_d;
`endif

    always_comb begin
        state_d         = state_q;
        array_d         = array_q;
        bad_d           = bad_q;
        size_addr_d     = size_addr_q;
        size_we_d       = 1'b0;
        size_wdata_d    = size_wdata_q;
        heap_addr_d     = heap_addr_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_underflow_d = rsp_underflow_q;
`ifdef HEAP_ARRAY_POP_CLEAR_EN
        heap_we_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    array_d     = req_array;
                    bad_d       = (req_array >= NArraysE);
                    size_addr_d = (req_array >= NArraysE) ? '0 : req_array[SizeAddrW-1:0];
                    state_d     = RD_SIZE;
                end
            end
            RD_SIZE: state_d = CHECK;
            CHECK: begin
                if (pop_fail) begin
                    rsp_underflow_d = 1'b1;
                    rsp_data_d      = '0;
                    rsp_valid_d     = 1'b1;
                    state_d         = RESP;
                end else begin
                    size_we_d    = 1'b1;
                    size_wdata_d = new_size;
                    heap_addr_d  = slot_idx[HeapAddrW-1:0];
                    state_d      = RD_HEAP;
                end
            end
            RD_HEAP: state_d = WAIT_HEAP;
            WAIT_HEAP: begin
                rsp_data_d      = heap_rdata;
                rsp_underflow_d = 1'b0;
`ifdef HEAP_ARRAY_POP_CLEAR_EN
                heap_we_d       = 1'b1;
                state_d         = CLEAR;
`else
                rsp_valid_d     = 1'b1;
                state_d         = RESP;
`endif
            end
            CLEAR: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            array_q         <= '0;
            bad_q           <= 1'b0;
            size_addr_q     <= '0;
            size_we_q       <= 1'b0;
            size_wdata_q    <= '0;
            heap_addr_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            array_q         <= array_d;
            bad_q           <= bad_d;
            size_addr_q     <= size_addr_d;
            size_we_q       <= size_we_d;
            size_wdata_q    <= size_wdata_d;
            heap_addr_q     <= heap_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_underflow_q <= rsp_underflow_d;
        end
    end

`ifdef HEAP_ARRAY_POP_CLEAR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            heap_we_q <= 1'b0;
        end else begin
            heap_we_q <= heap_we_d;
        end
    end
    assign heap_we = heap_we_q;
`else
    assign heap_we = 1'b0;
`endif

    // The only heap write ever issued is the slot clear, so the data is constant zero.
    assign heap_wdata    = '0;
    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_underflow = rsp_underflow_q;
    assign size_addr     = size_addr_q;
    assign size_we       = size_we_q;
    assign size_wdata    = size_wdata_q;
    assign heap_addr     = heap_addr_q;

endmodule

// File: tb/tb_heap_array_pop.sv
// Directed plus randomized bench for heap_array_pop against a queue-free array model of pop semantics.
module tb_heap_array_pop;

`ifdef HEAP_ARRAY_POP_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_array;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_data;
    logic        rsp_underflow;
    logic [10:0] size_addr;
    logic [11:0] size_rdata;
    logic        size_we;
    logic [11:0] size_wdata;
    logic [13:0] heap_addr;
    logic [11:0] heap_rdata;
    logic        heap_we;
    logic [11:0] heap_wdata;

    heap_array_pop dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_array(req_array),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_underflow(rsp_underflow),
        .size_addr(size_addr), .size_rdata(size_rdata), .size_we(size_we), .size_wdata(size_wdata),
        .heap_addr(heap_addr), .heap_rdata(heap_rdata), .heap_we(heap_we), .heap_wdata(heap_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAMs seen by the DUT, and the reference model's own view of them
    logic [11:0] size_mem [2048];
    logic [11:0] heap_mem [16384];
    logic [11:0] ref_size [2048];
    logic [11:0] ref_heap [16384];

    int total = 0;
    int bad   = 0;

    int          size_we_cnt = 0;
    int          heap_we_cnt = 0;
    int          pulse_viol  = 0;
    logic        size_we_p   = 1'b0;
    logic        heap_we_p   = 1'b0;
    logic [10:0] last_sw_addr;
    logic [11:0] last_sw_data;
    logic [13:0] last_hw_addr;
    logic [11:0] last_hw_data;

    always @(posedge clock) begin
        size_rdata <= size_mem[size_addr];
        heap_rdata <= heap_mem[heap_addr];
        if (size_we) size_mem[size_addr] <= size_wdata;
        if (heap_we) heap_mem[heap_addr] <= heap_wdata;
    end

    always @(posedge clock) begin
        if (size_we) begin
            size_we_cnt  <= size_we_cnt + 1;
            last_sw_addr <= size_addr;
            last_sw_data <= size_wdata;
        end
        if (heap_we) begin
            heap_we_cnt  <= heap_we_cnt + 1;
            last_hw_addr <= heap_addr;
            last_hw_data <= heap_wdata;
        end
        if ((size_we && size_we_p) || (heap_we && heap_we_p)) pulse_viol <= pulse_viol + 1;
        size_we_p <= size_we;
        heap_we_p <= heap_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_size(input int arr, input int sz);
        size_mem[arr] <= 12'(sz);
        ref_size[arr] = 12'(sz);
    endtask

    task automatic set_heap(input int idx, input logic [11:0] val);
        heap_mem[idx] <= val;
        ref_heap[idx] = val;
    endtask

    // Pop semantics: last element of the array area, or underflow when empty/corrupt/out of range.
    task automatic ref_pop(input int arr, output logic [11:0] d, output logic uf);
        int sz;
        int idx;
        d  = 12'd0;
        uf = 1'b1;
        if (arr < 2000) begin
            sz  = int'(ref_size[arr]);
            idx = arr * 10 + sz - 1;
            if (sz != 0 && sz <= 10 && idx < 10000) begin
                uf = 1'b0;
                d  = ref_heap[idx];
                ref_size[arr] = 12'(sz - 1);
                if (CLR) ref_heap[idx] = 12'd0;
            end
        end
    endtask

    task automatic do_pop(input logic [11:0] arr, input int hold, input bit pre_ready,
                          output logic [11:0] got_d, output logic got_uf);
        logic [11:0] exp_d;
        logic        exp_uf;
        int          exp_lat;
        int          lat;
        int          sw0;
        int          hw0;
        int          exp_idx;
        exp_idx = int'(arr) * 10 + int'(ref_size[int'(arr) % 2048]) - 1;
        ref_pop(int'(arr), exp_d, exp_uf);
        exp_lat = exp_uf ? 2 : (CLR ? 5 : 4);
        sw0 = size_we_cnt;
        hw0 = heap_we_cnt;
        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_array = arr;
        rsp_ready = pre_ready;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        got_d  = rsp_data;
        got_uf = rsp_underflow;
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_underflow", rsp_underflow, exp_uf);
        if (rsp_valid) begin
            if (!pre_ready) begin
                for (int i = 0; i < hold; i++) begin
                    @(posedge clock);
                    #1;
                    chk("hold_valid", rsp_valid, 1);
                    chk("hold_data", rsp_data, exp_d);
                    chk("hold_req_ready", req_ready, 0);
                end
                rsp_ready = 1'b1;
            end
            @(posedge clock);
            #1;
            rsp_ready = 1'b0;
            chk("valid_dropped", rsp_valid, 0);
            chk("req_ready_back", req_ready, 1);
        end
        chk("size_we_count", size_we_cnt - sw0, exp_uf ? 0 : 1);
        chk("heap_we_count", heap_we_cnt - hw0, (!exp_uf && CLR) ? 1 : 0);
        if (!exp_uf) begin
            chk("size_waddr", last_sw_addr, arr);
            chk("size_wdata", last_sw_data, ref_size[int'(arr)]);
            chk("size_mem", size_mem[int'(arr)], ref_size[int'(arr)]);
            if (CLR) begin
                chk("clear_addr", last_hw_addr, exp_idx);
                chk("clear_data", last_hw_data, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] d;
        logic        uf;
        int          arrs [10];
        int          arr;
        arrs = '{0, 1, 2, 5, 7, 999, 1000, 1999, 2000, 4095};
        reset     = 1'b0;
        req_valid = 1'b0;
        req_array = 12'd0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            size_mem[i] <= 12'd0;
            ref_size[i] = 12'd0;
        end
        for (int i = 0; i < 16384; i++) begin
            heap_mem[i] <= 12'd0;
            ref_heap[i] = 12'd0;
        end

        // reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_underflow", rsp_underflow, 0);
        chk("rst_size_we", size_we, 0);
        chk("rst_heap_we", heap_we, 0);
        chk("rst_size_addr", size_addr, 0);
        chk("rst_heap_addr", heap_addr, 0);
        chk("rst_size_wdata", size_wdata, 0);
        chk("rst_heap_wdata", heap_wdata, 0);
        reset = 1'b1;

        // array 0: two pops, then underflow
        set_size(0, 2);
        set_heap(0, 12'd1);
        set_heap(1, 12'd2);
        do_pop(12'd0, 0, 1'b0, d, uf);
        chk("tp1_first", d, 12'd2);
        do_pop(12'd0, 1, 1'b0, d, uf);
        chk("tp1_second", d, 12'd1);
        do_pop(12'd0, 0, 1'b0, d, uf);
        chk("tp1_underflow", uf, 1);

        // array 3 full, held response
        set_size(3, 10);
        set_heap(39, 12'hABC);
        do_pop(12'd3, 5, 1'b0, d, uf);
        chk("tp3_data", d, 12'hABC);
        chk("tp3_heap_addr", heap_addr, 39);
        chk("tp3_size_mem", size_mem[3], 12'd9);

        // out-of-range array, corrupt size, out-of-range slot
        do_pop(12'd2000, 0, 1'b0, d, uf);
        chk("tp4_range", uf, 1);
        set_size(5, 11);
        do_pop(12'd5, 0, 1'b1, d, uf);
        chk("tp4_corrupt", uf, 1);
        set_size(1000, 1);
        do_pop(12'd1000, 0, 1'b0, d, uf);
        chk("tp4_slot_range", uf, 1);
        set_size(999, 10);
        set_heap(9999, 12'h5A5);
        do_pop(12'd999, 0, 1'b1, d, uf);
        chk("tp4_last_slot", d, 12'h5A5);

        // reset during WAIT_HEAP: size write stands, no response
        set_size(4, 3);
        set_heap(40, 12'h111);
        set_heap(41, 12'h222);
        set_heap(42, 12'h333);
        @(negedge clock);
        req_valid = 1'b1;
        req_array = 12'd4;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req_ready", req_ready, 1);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_size_we", size_we, 0);
        chk("mid_heap_we", heap_we, 0);
        chk("mid_size_addr", size_addr, 0);
        chk("mid_heap_addr", heap_addr, 0);
        @(negedge clock);
        reset = 1'b1;
        ref_size[4] = 12'd2;
        repeat (3) begin
            @(negedge clock);
            chk("mid_no_rsp", rsp_valid, 0);
        end
        chk("mid_size_stands", size_mem[4], 12'd2);
        do_pop(12'd4, 0, 1'b0, d, uf);
        chk("mid_next_lower", d, 12'h222);

        // randomized pops
        for (int n = 0; n < 40; n++) begin
            arr = arrs[$urandom_range(0, 9)];
            if (arr < 2048 && $urandom_range(0, 1) == 1) begin
                set_size(arr, $urandom_range(0, 11));
                for (int k = 0; k < 10; k++) begin
                    if (arr * 10 + k < 16384) set_heap(arr * 10 + k, 12'($urandom_range(0, 4095)));
                end
            end
            do_pop(12'(arr), $urandom_range(0, 3), 1'($urandom_range(0, 1)), d, uf);
        end

        chk("pulse_width", pulse_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heap_array_pop.md
Name: heap_array_pop

Overview:
- Pops the last element from a heap-resident array. This is the read-side counterpart of the program-level push, which writes heapMem[array*NArea + size] and then increments the size.
- Owns the read-modify-write of the array-size table and the heap read for one pop at a time.
- Sits between the instruction sequencer and the shared size/heap synchronous RAMs.
- Reports underflow instead of corrupting state.

Parameters:
- MemoryElementWidth, 12, width of heap elements, sizes and array numbers
- NArea, 10, elements per array area; heap address = array*NArea + index
- NArrays, 2000, entries in the array-size table
- NHeap, 10000, heap memory depth

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  pop request
- req_ready  out  1  high only in IDLE
- req_array  in  MemoryElementWidth  array number to pop
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  MemoryElementWidth  popped element (0 on underflow)
- rsp_underflow  out  1  array was empty; nothing changed
- size_addr  out  $clog2(NArrays)  size-table address
- size_rdata  in  MemoryElementWidth  size-table read data, 1-cycle latency
- size_we  out  1  size-table write strobe
- size_wdata  out  MemoryElementWidth  new size
- heap_addr  out  $clog2(NHeap)  heap address
- heap_rdata  in  MemoryElementWidth  heap read data, 1-cycle latency
- heap_we  out  1  heap write strobe (used only with the optional feature)
- heap_wdata  out  MemoryElementWidth  heap write data

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_underflow=0.
  - size_we=0, heap_we=0; all addresses and write data 0.
- Handshake:
  - A request is accepted on a rising edge where req_valid and req_ready are both high; req_array is latched at that edge.
  - The response is held stable while rsp_valid is high and rsp_ready is low.
- States:
  - IDLE: on accept, drive size_addr=req_array and go to RD_SIZE.
  - RD_SIZE: wait one cycle for size_rdata.
  - CHECK:
    - If size_rdata==0: set rsp_underflow=1 and rsp_data=0, then go to RESP. No size or heap write.
    - Otherwise: latch s=size_rdata-1, drive heap_addr=array*NArea+s, go to RD_HEAP.
  - RD_HEAP: assert size_we with size_wdata=s, then go to WAIT_HEAP.
  - WAIT_HEAP: capture heap_rdata into rsp_data, set rsp_underflow=0, go to RESP (or CLEAR with the optional feature).
  - RESP: rsp_valid=1. When rsp_ready is high, deassert rsp_valid and go to IDLE.
- Latency: accept to rsp_valid is 4 cycles on success and 2 cycles on underflow. rsp_ready may already be high when rsp_valid rises.
- Arithmetic:
  - The heap address is computed at $clog2(NHeap)+1 bits.
  - If req_array>=NArrays, or array*NArea+s>=NHeap, treat the request as underflow; no memory access occurs.
  - A size value greater than NArea is also treated as underflow (corrupt table).
- Write strobes: size_we and heap_we are single-cycle pulses.
- Back-to-back: a new request is accepted in the cycle after the RESP handshake completes (req_ready returns high in IDLE).
- Reset mid-operation: the block returns to IDLE immediately. A size write already performed stands; a pending one is dropped. No response is emitted.

Optional Feature:
- Macro: HEAP_ARRAY_POP_CLEAR_EN.
- When defined: after WAIT_HEAP, a CLEAR state writes 0 to the popped heap slot (heap_we=1 for one cycle, heap_wdata=0). Success latency becomes 5 cycles.
- When undefined: heap_we is tied to 0, the CLEAR state does not exist, and the popped slot retains its old value.

Decomposition:
- Package heap_array_pkg: MemoryElementWidth, NArea, NArrays, NHeap defaults; an element typedef; a state enum (IDLE, RD_SIZE, CHECK, RD_HEAP, WAIT_HEAP, CLEAR, RESP); and a function heap_index(array, index).
- No sub-module: the heap address multiply-add is the package function, and the RAMs stay external.

Test Plan:
- Array 0 size=2, heap[0]=1, heap[1]=2; pop array 0 -> rsp_data=2, underflow=0, size written 1; pop again -> rsp_data=1, size written 0.
- Third pop on array 0 (size 0) -> rsp_underflow=1, rsp_data=0; no size_we, no heap_we; response 2 cycles after accept.
- Array 3 size=10, heap[39]=0xABC; pop -> rsp_data=0xABC, heap_addr=39, size written 9; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
- req_array=2000 -> underflow=1 with no memory strobes; array 5 with size table value 11 -> underflow=1.
- reset driven low during WAIT_HEAP -> outputs at reset values immediately; next pop on the same array returns the next-lower element.
- With HEAP_ARRAY_POP_CLEAR_EN defined: pop array 0 (size 2) -> heap_we pulse at address 1 with data 0, rsp_valid 5 cycles after accept.
